// File: rtl/recovery_update_pipe_if.sv
// Request/response bundle for recovery_update_pipe.
//   slave  : the pipeline (consumes requests, produces results)
//   master : the requester/consumer side
// Request channel : in_valid, in_ready, in_idx, in_v, in_spike
// Result channel  : out_valid, out_ready, out_idx, out_w, out_dw
interface recovery_update_pipe_if #(
  parameter int N  = 32,
  parameter int IW = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IW-1:0]        in_idx;
  logic signed [N-1:0]  in_v;
  logic                 in_spike;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_idx;
  logic signed [N-1:0]  out_w;
  logic signed [N-1:0]  out_dw;

  modport slave (
    input  in_valid, in_idx, in_v, in_spike, out_ready,
    output in_ready, out_valid, out_idx, out_w, out_dw
  );

  modport master (
    output in_valid, in_idx, in_v, in_spike, out_ready,
    input  in_ready, out_valid, out_idx, out_w, out_dw
  );
endinterface

// File: rtl/recovery_update_pipe.sv
// Three-stage fixed-point update of a per-neuron recovery variable w:
//   dw = a*(b*v - w)*step ; w_new = w + dw (+ d when the neuron spiked)
// The w state for NEURONS neurons is held internally and written back
// when a result is handed off downstream.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   bus (slave)    : request channel (in_*) and result channel (out_*)
//   a, b, d, step  : model constants, each used by the stage that needs it
module recovery_update_pipe #(
  parameter int                 N       = 32,
  parameter int                 Q       = 16,
  parameter int                 NEURONS = 4,
  parameter logic signed [N-1:0] W_INIT = '0,
  localparam int                IW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  recovery_update_pipe_if.slave bus,
  input  logic signed [N-1:0]  a,
  input  logic signed [N-1:0]  b,
  input  logic signed [N-1:0]  d,
  input  logic signed [N-1:0]  step
);

  localparam logic signed [2*N-1:0] MAX_W = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_W = {{(N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [IW:0]           NEURONS_L = (IW+1)'(NEURONS);

  function automatic logic signed [N-1:0] sat_wide(input logic signed [2*N-1:0] x);
    logic signed [N-1:0] r;
    if (x > MAX_W)      r = MAX_W[N-1:0];
    else if (x < MIN_W) r = MIN_W[N-1:0];
    else                r = x[N-1:0];
    return r;
  endfunction

  // Full-width signed product, floor shift by Q, then saturate.
  function automatic logic signed [N-1:0] fx_mul(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
    logic signed [2*N-1:0] xe;
    logic signed [2*N-1:0] ye;
    logic signed [2*N-1:0] p;
    xe = {{N{x[N-1]}}, x};
    ye = {{N{y[N-1]}}, y};
    p  = (xe * ye) >>> Q;
    return sat_wide(p);
  endfunction

  function automatic logic signed [N-1:0] fx_add(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
    return sat_wide({{N{x[N-1]}}, x} + {{N{y[N-1]}}, y});
  endfunction

  function automatic logic signed [N-1:0] fx_sub(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
    return sat_wide({{N{x[N-1]}}, x} - {{N{y[N-1]}}, y});
  endfunction

  logic signed [N-1:0] w_mem [NEURONS];

  logic                s1_valid, s2_valid, s3_valid;
  logic [IW-1:0]       s1_idx, s2_idx, s3_idx;
  logic                s1_spike, s2_spike;
  logic signed [N-1:0] s1_w, s2_w;
  logic signed [N-1:0] s1_diff, s2_t;
  logic signed [N-1:0] s3_w, s3_dw;

  logic                stall, hazard, accept;
  logic                in_range, wb_en;
  logic signed [N-1:0] w_rd, diff_c, t_c, dw_c, wsum_c, wnew_c;

  // Any stage holding the requested index blocks it; there is no forwarding,
  // so the w read in S1 is always the committed value.
  assign stall  = s3_valid && !bus.out_ready;
  assign hazard = (s1_valid && (s1_idx == bus.in_idx)) ||
                  (s2_valid && (s2_idx == bus.in_idx)) ||
                  (s3_valid && (s3_idx == bus.in_idx));
  assign bus.in_ready = !stall && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  assign in_range = ({1'b0, bus.in_idx} < NEURONS_L);
  assign w_rd     = in_range ? w_mem[bus.in_idx] : W_INIT;
  assign diff_c   = fx_sub(fx_mul(b, bus.in_v), w_rd);
  assign t_c      = fx_mul(a, s1_diff);
  assign dw_c     = fx_mul(s2_t, step);
  assign wsum_c   = fx_add(s2_w, dw_c);
  assign wnew_c   = s2_spike ? fx_add(wsum_c, d) : wsum_c;

  assign wb_en = s3_valid && bus.out_ready && ({1'b0, s3_idx} < NEURONS_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_spike <= 1'b0;
      s1_w     <= '0;
      s1_diff  <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_spike <= 1'b0;
      s2_w     <= '0;
      s2_t     <= '0;
      s3_valid <= 1'b0;
      s3_idx   <= '0;
      s3_w     <= '0;
      s3_dw    <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_idx   <= bus.in_idx;
      s1_spike <= bus.in_spike;
      s1_w     <= w_rd;
      s1_diff  <= diff_c;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_spike <= s1_spike;
      s2_w     <= s1_w;
      s2_t     <= t_c;
      s3_valid <= s2_valid;
      s3_idx   <= s2_idx;
      s3_w     <= wnew_c;
      s3_dw    <= dw_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NEURONS; i++) w_mem[i] <= W_INIT;
    end else if (wb_en) begin
      w_mem[s3_idx] <= s3_w;
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_idx   = s3_idx;
  assign bus.out_w     = s3_w;
  assign bus.out_dw    = s3_dw;

endmodule

// File: doc/recovery_update_pipe.md
RECOVERY_UPDATE_PIPE -- requirements
Module: recovery_update_pipe

Interface
REQ-001 Parameter N, default 32: total word width, signed two's complement fixed point.
REQ-002 Parameter Q, default 16: fractional bits of every fixed-point value.
REQ-003 Parameter NEURONS, default 4: number of neurons whose w state is held internally; IW = max(1, clog2(NEURONS)).
REQ-004 Parameter W_INIT, default 0: reset value of every stored w (N-bit signed fixed point).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-009 in_idx  input  IW  neuron index; values >= NEURONS are ignored (see REQ-021).
REQ-010 in_v  input  N  membrane voltage v.
REQ-011 in_spike  input  1  neuron fired this step; add d after the update.
REQ-012 a, b, d, step  input  N each  model constants; sampled only at the cycle each pipeline stage uses them.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_idx  output  IW  neuron index of the result.
REQ-016 out_w  output  N  updated w.
REQ-017 out_dw  output  N  increment a*(b*v - w)*step, before the spike term.

Function
REQ-018 Every multiply shall form the full 2N-bit signed product, shift it arithmetically right by Q (floor), then saturate to N-bit signed.
REQ-019 Every add or subtract shall saturate to [-2^(N-1), 2^(N-1)-1].
REQ-020 The block shall be a 3-stage pipeline:
- S1: read w[idx]; diff = sat(mul(b,v) - w).
- S2: t = mul(a,diff).
- S3: dw = mul(t,step); w_new = sat(w + dw), then sat(w_new + d) if spike.
- S3 registers drive out_*.
REQ-021 Out-of-range in_idx: the request shall still be accepted and produce a result; out_w equals the computed value, and no storage write occurs.
REQ-022 Latency: with out_ready held high, out_valid rises exactly 3 cycles after acceptance; throughput is one request per cycle when no hazard exists.
REQ-023 Stall: when out_valid && !out_ready, all stages hold, and out_idx/out_w/out_dw stay stable.
REQ-024 Writeback: w[out_idx] <= out_w at the edge where out_valid && out_ready.
REQ-025 Hazard: in_ready is low whenever in_idx equals the index of any valid in-flight entry (S1-S3); no forwarding.
REQ-026 in_ready = !stall && !hazard; in_ready may depend combinationally on in_idx.
REQ-027 A request is accepted in the same cycle as a writeback to a different index; if it is the same index, REQ-025 blocks it.
REQ-028 Results shall emerge in acceptance order.

Reset
REQ-029 While reset is high:
- all stage valid bits shall be 0, so out_valid = 0;
- out_idx, out_w and out_dw shall be 0;
- every stored w shall be W_INIT.
REQ-030 Reset mid-operation shall discard all in-flight requests with no writeback.
REQ-031 In the first cycle after reset deasserts, in_ready = 1.

Verification
REQ-032 The bench shall cover these directed scenarios (N=32, Q=16, W_INIT=0):
- Basic: a=1311, b=13107, step=65536, idx 0, v=-65.0 (-4259840), no spike -> 3 cycles later out_dw=-17043, out_w=-17043; stored w[0]=-17043.
- Spike: same constants, d=524288, idx 1, spike=1 -> out_w=507245, out_dw=-17043.
- Saturation: a=b=step=0x7FFFFFFF, v=0x7FFFFFFF, w=0 -> out_w=0x7FFFFFFF; negative v=0x80000000 -> out_w=0x80000000.
- Hazard: back-to-back requests to idx 2 -> in_ready low until the first result handshakes; the second result uses the written-back w. Idx 0,1,2,3 back-to-back -> 4 results in 4 consecutive cycles.
- Backpressure: out_ready low for 5 cycles with 3 in flight -> outputs stable, in_ready=0, no loss or reordering.
- Reset mid-flight with 2 requests pending -> out_valid=0 next cycle, w stays W_INIT, no outputs after release.
